// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds PC, fetches one word per instruction, computes next PC.
// Optional PC_ALIGN_CHECK_EN redirects misaligned next PCs to EXC_VECTOR.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCSource,
  input  logic [2:0]  Branch,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        misalign_err
);

  localparam int unsigned XLEN = 32;
`ifdef PC_ALIGN_CHECK_EN
  localparam logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0080;
`endif

  typedef enum logic [1:0] {BOOT, FETCH, EXEC} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;

  logic            taken;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] next_pc;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Branch condition on two's-complement operands
  always_comb begin
    taken = 1'b0;
    unique case (Branch)
      3'b100:  taken = (rs_data == rt_data);
      3'b101:  taken = (rs_data != rt_data);
      3'b110:  taken = ($signed(rs_data) <= $signed(XLEN'(0)));
      3'b111:  taken = ($signed(rs_data) >  $signed(XLEN'(0)));
      3'b001:  taken = rs_data[XLEN-1];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc_plus4;
    if (PCSource == 2'b10) begin
      if (instr_q[31:26] == 6'd0) next_pc = rs_data;
      else                        next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (taken) begin
      next_pc = pc_plus4 + br_off;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    mis_d   = 1'b0;
    unique case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          state_d = FETCH;
`ifdef PC_ALIGN_CHECK_EN
          if (next_pc[1:0] != 2'b00) begin
            pc_d  = EXC_VECTOR;
            mis_d = 1'b1;
          end else begin
            pc_d  = next_pc;
          end
`else
          pc_d = next_pc & ~XLEN'(3);
`endif
        end
      end
      default: state_d = BOOT;
    endcase
    req_d   = (state_d == FETCH);
    valid_d = (state_d == EXEC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr        = instr_q;
  assign OpCode       = instr_q[31:26];
  assign Funct        = instr_q[5:0];
  assign instr_valid  = valid_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequencing, branches, jumps, wait states, stall, wrap, reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  PCSource;
  logic [2:0]  Branch;
  logic [31:0] rs_data, rt_data;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr;
  logic [5:0]  OpCode, Funct;
  logic [31:0] pc, pc_plus4;
  logic        instr_valid, misalign_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] JR_TGT = 32'h0000_0080;
  localparam logic        JR_MIS = 1'b1;
`else
  localparam logic [31:0] JR_TGT = 32'h0000_1000;
  localparam logic        JR_MIS = 1'b0;
`endif

  fetch_unit dut (
    .clk(clk), .reset(reset), .PCSource(PCSource), .Branch(Branch),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .instr(instr), .OpCode(OpCode), .Funct(Funct),
    .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction from a FETCH cycle with zero-wait memory through to the next FETCH
  task automatic run_instr(input string tag, input logic [31:0] word, input logic [1:0] pcs,
                           input logic [2:0] br, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] exp_next, input logic exp_mis);
    logic [5:0] op, fn;
    op = word[31:26];
    fn = word[5:0];
    check({tag, ".req"},   32'(imem_req), 32'd1);
    check({tag, ".addr"},  imem_addr, exp_pc);
    check({tag, ".vld0"},  32'(instr_valid), 32'd0);
    imem_rdata = word;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check({tag, ".vld1"},  32'(instr_valid), 32'd1);
    check({tag, ".instr"}, instr, word);
    check({tag, ".op"},    32'(OpCode), 32'(op));
    check({tag, ".fn"},    32'(Funct), 32'(fn));
    check({tag, ".pc4"},   pc_plus4, exp_pc + 32'd4);
    check({tag, ".ereq"},  32'(imem_req), 32'd0);
    PCSource = pcs;
    Branch   = br;
    rs_data  = rs;
    rt_data  = rt;
    stall    = 1'b0;
    step();
    PCSource = 2'b00;
    Branch   = 3'b000;
    check({tag, ".next"},  imem_addr, exp_next);
    check({tag, ".mis"},   32'(misalign_err), 32'(exp_mis));
    exp_pc = exp_next;
  endtask

  initial begin
    reset = 1'b1;
    PCSource = 2'b00; Branch = 3'b000; rs_data = '0; rt_data = '0;
    stall = 1'b0; imem_rdata = '0; imem_ready = 1'b1;
    repeat (2) step();
    check("rst.pc",    pc, 32'h0);
    check("rst.instr", instr, 32'h0);
    check("rst.vld",   32'(instr_valid), 32'd0);
    check("rst.req",   32'(imem_req), 32'd0);
    check("rst.mis",   32'(misalign_err), 32'd0);
    reset = 1'b0;
    imem_ready = 1'b0;
    check("boot.req", 32'(imem_req), 32'd0);
    step();
    exp_pc = 32'h0;

    run_instr("seq0", 32'h2000_0001, 2'b00, 3'b000, 32'h0, 32'h0, 32'h4, 1'b0);
    run_instr("seq1", 32'h2000_0002, 2'b00, 3'b000, 32'h0, 32'h0, 32'h8, 1'b0);
    run_instr("j",    32'h0800_0008, 2'b10, 3'b000, 32'h0, 32'h0, 32'h20, 1'b0);
    run_instr("beq",  32'h1000_FFFE, 2'b01, 3'b100, 32'd5, 32'd5, 32'h1C, 1'b0);
    run_instr("bnent",32'h1400_FFFE, 2'b00, 3'b101, 32'd5, 32'd5, 32'h20, 1'b0);
    run_instr("bne",  32'h1400_FFFE, 2'b00, 3'b101, 32'd5, 32'd5, 32'h24, 1'b0);
    run_instr("bltz", 32'h0400_0004, 2'b00, 3'b001, 32'h8000_0000, 32'h0, 32'h38, 1'b0);
    run_instr("bgtz", 32'h1C00_0004, 2'b00, 3'b111, 32'h0, 32'h0, 32'h3C, 1'b0);
    run_instr("blez", 32'h1800_0004, 2'b00, 3'b110, 32'h0, 32'h0, 32'h50, 1'b0);
    run_instr("jr",   32'h0000_0008, 2'b10, 3'b000, 32'h0000_1002, 32'h0, JR_TGT, JR_MIS);

    // Three wait cycles, then accept on the fourth FETCH cycle
    for (int i = 0; i < 3; i++) begin
      check("wait.addr", imem_addr, exp_pc);
      check("wait.req",  32'(imem_req), 32'd1);
      step();
    end
    check("wait.mis",  32'(misalign_err), 32'd0);
    check("wait.vld",  32'(instr_valid), 32'd0);
    check("wait.addr4", imem_addr, exp_pc);
    imem_rdata = 32'h1000_0010;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    check("wait.instr", instr, 32'h1000_0010);

    // Stall with a taken beq pending; pc must hold until stall drops
    PCSource = 2'b01; Branch = 3'b100; rs_data = 32'd7; rt_data = 32'd7;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall.pc",  pc, exp_pc);
      check("stall.vld", 32'(instr_valid), 32'd1);
      check("stall.req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    step();
    PCSource = 2'b00; Branch = 3'b000;
    check("stall.next", imem_addr, exp_pc + 32'h44);
    exp_pc = exp_pc + 32'h44;

    run_instr("jrtop", 32'h0000_0008, 2'b10, 3'b000, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1'b0);
    run_instr("wrap",  32'h2000_0003, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    run_instr("seq2",  32'h2000_0004, 2'b00, 3'b000, 32'h0, 32'h0, 32'h4, 1'b0);

    // Asynchronous reset mid-FETCH drops the request immediately
    check("prerst.req", 32'(imem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst.req", 32'(imem_req), 32'd0);
    check("arst.pc",  pc, 32'h0);
    step();
    reset = 1'b0;
    check("rel.req", 32'(imem_req), 32'd0);
    step();
    check("rel.req2",  32'(imem_req), 32'd1);
    check("rel.addr",  imem_addr, 32'h0);
    exp_pc = 32'h0;
    run_instr("post", 32'h2000_0005, 2'b00, 3'b000, 32'h0, 32'h0, 32'h4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
